// File: rtl/wb_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_2x1
// Brief    : Round-robin pipelined Wishbone arbiter, two initiators to one target.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_2x1 #(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,

    input  logic                  itr0_cyc_i,
    input  logic                  itr0_stb_i,
    input  logic                  itr0_we_i,
    input  logic                  itr0_lock_i,
    input  logic [SEL_WIDTH-1:0]  itr0_sel_i,
    input  logic [ADR_WIDTH-1:0]  itr0_adr_i,
    input  logic [DAT_WIDTH-1:0]  itr0_dat_i,
    input  logic [TGA_WIDTH-1:0]  itr0_tga_i,
    input  logic [TGC_WIDTH-1:0]  itr0_tgc_i,
    input  logic [TGWD_WIDTH-1:0] itr0_tgd_i,
    output logic                  itr0_ack_o,
    output logic                  itr0_err_o,
    output logic                  itr0_rty_o,
    output logic                  itr0_stall_o,
    output logic [DAT_WIDTH-1:0]  itr0_dat_o,
    output logic [TGRD_WIDTH-1:0] itr0_tgd_o,

    input  logic                  itr1_cyc_i,
    input  logic                  itr1_stb_i,
    input  logic                  itr1_we_i,
    input  logic                  itr1_lock_i,
    input  logic [SEL_WIDTH-1:0]  itr1_sel_i,
    input  logic [ADR_WIDTH-1:0]  itr1_adr_i,
    input  logic [DAT_WIDTH-1:0]  itr1_dat_i,
    input  logic [TGA_WIDTH-1:0]  itr1_tga_i,
    input  logic [TGC_WIDTH-1:0]  itr1_tgc_i,
    input  logic [TGWD_WIDTH-1:0] itr1_tgd_i,
    output logic                  itr1_ack_o,
    output logic                  itr1_err_o,
    output logic                  itr1_rty_o,
    output logic                  itr1_stall_o,
    output logic [DAT_WIDTH-1:0]  itr1_dat_o,
    output logic [TGRD_WIDTH-1:0] itr1_tgd_o,

    output logic                  tgt_cyc_o,
    output logic                  tgt_stb_o,
    output logic                  tgt_we_o,
    output logic                  tgt_lock_o,
    output logic [SEL_WIDTH-1:0]  tgt_sel_o,
    output logic [ADR_WIDTH-1:0]  tgt_adr_o,
    output logic [DAT_WIDTH-1:0]  tgt_dat_o,
    output logic [TGA_WIDTH-1:0]  tgt_tga_o,
    output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
    output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
    input  logic                  tgt_ack_i,
    input  logic                  tgt_err_i,
    input  logic                  tgt_rty_i,
    input  logic                  tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0] tgt_tgd_i,

    output logic [1:0]            arb_gnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  gnt0, gnt1, full, acc, rsp;

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);
    assign full = (cnt_q == CNT_MAX);

    always_comb begin
        tgt_cyc_o  = 1'b0;
        tgt_stb_o  = 1'b0;
        tgt_we_o   = 1'b0;
        tgt_lock_o = 1'b0;
        tgt_sel_o  = '0;
        tgt_adr_o  = '0;
        tgt_dat_o  = '0;
        tgt_tga_o  = '0;
        tgt_tgc_o  = '0;
        tgt_tgd_o  = '0;
        case (state_q)
            ST_GNT0: begin
                tgt_cyc_o  = itr0_cyc_i;
                tgt_stb_o  = itr0_stb_i & ~full;
                tgt_we_o   = itr0_we_i;
                tgt_lock_o = itr0_lock_i;
                tgt_sel_o  = itr0_sel_i;
                tgt_adr_o  = itr0_adr_i;
                tgt_dat_o  = itr0_dat_i;
                tgt_tga_o  = itr0_tga_i;
                tgt_tgc_o  = itr0_tgc_i;
                tgt_tgd_o  = itr0_tgd_i;
            end
            ST_GNT1: begin
                tgt_cyc_o  = itr1_cyc_i;
                tgt_stb_o  = itr1_stb_i & ~full;
                tgt_we_o   = itr1_we_i;
                tgt_lock_o = itr1_lock_i;
                tgt_sel_o  = itr1_sel_i;
                tgt_adr_o  = itr1_adr_i;
                tgt_dat_o  = itr1_dat_i;
                tgt_tga_o  = itr1_tga_i;
                tgt_tgc_o  = itr1_tgc_i;
                tgt_tgd_o  = itr1_tgd_i;
            end
            default: ;
        endcase
    end

    // Responses with nothing outstanding are dropped here, so the owner never sees them.
    assign acc = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
    assign rsp = tgt_cyc_o & (tgt_ack_i | tgt_err_i | tgt_rty_i) & (cnt_q != CNT_ZERO);

    assign itr0_ack_o   = gnt0 & tgt_ack_i & rsp;
    assign itr0_err_o   = gnt0 & tgt_err_i & rsp;
    assign itr0_rty_o   = gnt0 & tgt_rty_i & rsp;
    assign itr0_stall_o = gnt0 ? (tgt_stall_i | full) : 1'b1;
    assign itr0_dat_o   = tgt_dat_i;
    assign itr0_tgd_o   = tgt_tgd_i;

    assign itr1_ack_o   = gnt1 & tgt_ack_i & rsp;
    assign itr1_err_o   = gnt1 & tgt_err_i & rsp;
    assign itr1_rty_o   = gnt1 & tgt_rty_i & rsp;
    assign itr1_stall_o = gnt1 ? (tgt_stall_i | full) : 1'b1;
    assign itr1_dat_o   = tgt_dat_i;
    assign itr1_tgd_o   = tgt_tgd_i;

    assign arb_gnt_o = {gnt1, gnt0};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (acc && !rsp) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (rsp && !acc) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                // On a tie the pointer names the last owner; the other one wins.
                if (itr0_cyc_i && (!itr1_cyc_i || ptr_q)) begin
                    state_d = ST_GNT0;
                    ptr_d   = 1'b0;
                end else if (itr1_cyc_i) begin
                    state_d = ST_GNT1;
                    ptr_d   = 1'b1;
                end
            end
            ST_GNT0: begin
                if (!itr0_cyc_i && !itr0_lock_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_GNT1: begin
                if (!itr1_cyc_i && !itr1_lock_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b1;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_2x1
// Brief    : Directed + randomized bench for wb_arbiter_2x1 against a bus-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2x1;

    localparam int MAXO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i0_cyc, i0_stb, i0_we, i0_lock, i0_tga, i0_tgc, i0_tgd;
    logic [1:0]  i0_sel;
    logic [15:0] i0_adr, i0_dat;
    logic        i1_cyc, i1_stb, i1_we, i1_lock, i1_tga, i1_tgc, i1_tgd;
    logic [1:0]  i1_sel;
    logic [15:0] i1_adr, i1_dat;
    logic        t_ack, t_err, t_rty, t_stall, t_tgd;
    logic [15:0] t_dat;

    logic        o0_ack, o0_err, o0_rty, o0_stall, o0_tgd;
    logic [15:0] o0_dat;
    logic        o1_ack, o1_err, o1_rty, o1_stall, o1_tgd;
    logic [15:0] o1_dat;
    logic        o_cyc, o_stb, o_we, o_lock, o_tga, o_tgc, o_tgd;
    logic [1:0]  o_sel;
    logic [15:0] o_adr, o_dat;
    logic [1:0]  o_gnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus, who owned it last, accesses in flight.
    int owner  = -1;
    int last   = 1;
    int outst  = 0;

    always #5 clk = ~clk;

    wb_arbiter_2x1 dut (
        .clk_i(clk), .async_rst_i(rst),
        .itr0_cyc_i(i0_cyc), .itr0_stb_i(i0_stb), .itr0_we_i(i0_we), .itr0_lock_i(i0_lock),
        .itr0_sel_i(i0_sel), .itr0_adr_i(i0_adr), .itr0_dat_i(i0_dat),
        .itr0_tga_i(i0_tga), .itr0_tgc_i(i0_tgc), .itr0_tgd_i(i0_tgd),
        .itr0_ack_o(o0_ack), .itr0_err_o(o0_err), .itr0_rty_o(o0_rty), .itr0_stall_o(o0_stall),
        .itr0_dat_o(o0_dat), .itr0_tgd_o(o0_tgd),
        .itr1_cyc_i(i1_cyc), .itr1_stb_i(i1_stb), .itr1_we_i(i1_we), .itr1_lock_i(i1_lock),
        .itr1_sel_i(i1_sel), .itr1_adr_i(i1_adr), .itr1_dat_i(i1_dat),
        .itr1_tga_i(i1_tga), .itr1_tgc_i(i1_tgc), .itr1_tgd_i(i1_tgd),
        .itr1_ack_o(o1_ack), .itr1_err_o(o1_err), .itr1_rty_o(o1_rty), .itr1_stall_o(o1_stall),
        .itr1_dat_o(o1_dat), .itr1_tgd_o(o1_tgd),
        .tgt_cyc_o(o_cyc), .tgt_stb_o(o_stb), .tgt_we_o(o_we), .tgt_lock_o(o_lock),
        .tgt_sel_o(o_sel), .tgt_adr_o(o_adr), .tgt_dat_o(o_dat),
        .tgt_tga_o(o_tga), .tgt_tgc_o(o_tgc), .tgt_tgd_o(o_tgd),
        .tgt_ack_i(t_ack), .tgt_err_i(t_err), .tgt_rty_i(t_rty), .tgt_stall_i(t_stall),
        .tgt_dat_i(t_dat), .tgt_tgd_i(t_tgd),
        .arb_gnt_o(o_gnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        {i0_cyc, i0_stb, i0_we, i0_lock, i0_tga, i0_tgc, i0_tgd, i0_sel, i0_adr, i0_dat} = '0;
        {i1_cyc, i1_stb, i1_we, i1_lock, i1_tga, i1_tgc, i1_tgd, i1_sel, i1_adr, i1_dat} = '0;
        {t_ack, t_err, t_rty, t_stall, t_tgd, t_dat} = '0;
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        outst = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one cycle.
    task automatic step();
        logic [25:0] e_req;
        logic [15:0] e_adr, e_dat;
        logic        e_cyc, e_stb, may_rsp, accepted, responded, keep;
        int          n_owner, n_last, n_outst;
        #1;
        e_req = '0; e_adr = '0; e_dat = '0;
        if (owner == 0) begin
            e_req = {i0_cyc, i0_stb && (outst < MAXO), i0_we, i0_lock, i0_sel, i0_tga, i0_tgc, i0_tgd};
            e_adr = i0_adr; e_dat = i0_dat;
        end else if (owner == 1) begin
            e_req = {i1_cyc, i1_stb && (outst < MAXO), i1_we, i1_lock, i1_sel, i1_tga, i1_tgc, i1_tgd};
            e_adr = i1_adr; e_dat = i1_dat;
        end
        e_cyc   = e_req[8];
        e_stb   = e_req[7];
        may_rsp = e_cyc && (outst > 0);

        check_eq("tgt_req", {o_cyc, o_stb, o_we, o_lock, o_sel, o_tga, o_tgc, o_tgd}, e_req);
        check_eq("tgt_adr", o_adr, e_adr);
        check_eq("tgt_wdat", o_dat, e_dat);
        check_eq("gnt", o_gnt, {owner == 1, owner == 0});
        check_eq("itr0_rsp", {o0_ack, o0_err, o0_rty, o0_stall},
                 {owner == 0 && may_rsp && t_ack, owner == 0 && may_rsp && t_err,
                  owner == 0 && may_rsp && t_rty, owner == 0 ? (t_stall || outst == MAXO) : 1'b1});
        check_eq("itr1_rsp", {o1_ack, o1_err, o1_rty, o1_stall},
                 {owner == 1 && may_rsp && t_ack, owner == 1 && may_rsp && t_err,
                  owner == 1 && may_rsp && t_rty, owner == 1 ? (t_stall || outst == MAXO) : 1'b1});
        check_eq("itr0_rdat", {o0_tgd, o0_dat}, {t_tgd, t_dat});
        check_eq("itr1_rdat", {o1_tgd, o1_dat}, {t_tgd, t_dat});

        accepted  = e_cyc && e_stb && !t_stall;
        responded = may_rsp && (t_ack || t_err || t_rty);
        n_owner = owner; n_last = last; n_outst = outst;
        if (owner < 0) begin
            if (i0_cyc && i1_cyc) n_owner = (last == 0) ? 1 : 0;
            else if (i0_cyc)      n_owner = 0;
            else if (i1_cyc)      n_owner = 1;
            if (n_owner >= 0) n_last = n_owner;
        end else begin
            keep = (owner == 0) ? (i0_cyc || i0_lock) : (i1_cyc || i1_lock);
            if (keep) begin
                n_outst = outst + (accepted ? 1 : 0) - (responded ? 1 : 0);
            end else begin
                n_owner = -1;
                n_outst = 0;
            end
        end
        @(posedge clk);
        owner = n_owner; last = n_last; outst = n_outst;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", o_gnt, 2'b00);
        check_eq("rst_stall", {o0_stall, o1_stall, o_cyc}, 3'b110);
        rst = 1'b0;
        model_reset();

        // Single initiator gets the bus one cycle after cyc rises.
        i0_cyc = 1'b1; i0_stb = 1'b1; i0_adr = 16'hA5C3; i0_dat = 16'h1234; i0_sel = 2'b11;
        step();
        #1;
        check_eq("tp1_gnt", o_gnt, 2'b01);
        check_eq("tp1_adr", o_adr, 16'hA5C3);
        check_eq("tp1_stall1", o1_stall, 1'b1);

        // Stray ack while nothing is outstanding is swallowed.
        i0_stb = 1'b0; t_ack = 1'b1;
        #1;
        check_eq("tp4_stray_ack", o0_ack, 1'b0);
        step();

        // Three accepts fill the counter, the fourth strobe is held off.
        t_ack = 1'b0; i0_stb = 1'b1;
        repeat (3) step();
        #1;
        check_eq("tp3_full_stall", {o0_stall, o_stb}, 2'b10);
        step();
        t_ack = 1'b1;
        #1;
        check_eq("tp3_ack", o0_ack, 1'b1);
        step();
        t_ack = 1'b0;
        #1;
        check_eq("tp3_release", {o0_stall, o_stb}, 2'b01);
        step();

        // Handover: itr0 drops, idle gap, itr1 wins the tie since itr0 was last.
        i0_cyc = 1'b0; i0_stb = 1'b0;
        step();
        #1;
        check_eq("tp2_gap", {o_cyc, o_gnt}, 3'b000);
        i0_cyc = 1'b1; i1_cyc = 1'b1; i1_adr = 16'h0F0F;
        step();
        #1;
        check_eq("tp2_alt", o_gnt, 2'b10);

        // Lock keeps itr1 on the bus with cyc low.
        i1_lock = 1'b1; i1_cyc = 1'b0;
        repeat (3) begin
            step();
            #1;
            check_eq("tp5_hold", {o_gnt, o0_stall, o_cyc}, 4'b1010);
        end
        i1_lock = 1'b0;
        step();
        step();
        #1;
        check_eq("tp5_regrant", o_gnt, 2'b01);

        // Async reset in the middle of a cycle with two outstanding.
        i0_stb = 1'b1;
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        check_eq("tp6_async", {o_gnt, o_cyc, o_stb, o0_stall, o1_stall}, 6'b000011);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("tp6_after", o_gnt, 2'b00);
        idle_inputs();
        @(negedge clk);

        // Randomized traffic; cyc tends to persist so bursts and handovers both occur.
        for (int k = 0; k < 3000; k++) begin
            i0_cyc  = ($urandom_range(0, 4) != 0) ? i0_cyc : ~i0_cyc;
            i1_cyc  = ($urandom_range(0, 4) != 0) ? i1_cyc : ~i1_cyc;
            i0_lock = ($urandom_range(0, 9) == 0);
            i1_lock = ($urandom_range(0, 9) == 0);
            i0_stb  = $urandom_range(0, 1);
            i1_stb  = $urandom_range(0, 1);
            i0_we   = $urandom_range(0, 1);
            i1_we   = $urandom_range(0, 1);
            i0_sel  = 2'($urandom);
            i1_sel  = 2'($urandom);
            i0_adr  = 16'($urandom);
            i1_adr  = 16'($urandom);
            i0_dat  = 16'($urandom);
            i1_dat  = 16'($urandom);
            {i0_tga, i0_tgc, i0_tgd} = 3'($urandom);
            {i1_tga, i1_tgc, i1_tgd} = 3'($urandom);
            t_ack   = ($urandom_range(0, 2) == 0);
            t_err   = ($urandom_range(0, 9) == 0);
            t_rty   = ($urandom_range(0, 9) == 0);
            t_stall = ($urandom_range(0, 3) == 0);
            t_dat   = 16'($urandom);
            t_tgd   = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_2x1.md
Name: wb_arbiter_2x1

Overview:
Pipelined Wishbone arbiter that shares one target port between two initiators (itr0, itr1).
- Bus ownership is granted round-robin and is held for the whole bus cycle (cyc), and longer while lock is asserted.
- Request and response signals are muxed between the granted initiator and the target.
- A per-grant outstanding-request counter throttles the owner and discards stray responses.
- Sits between initiator-side logic and a crossbar target port, upstream of pass-through paths.

Parameters:
ADR_WIDTH 16: address bus width
DAT_WIDTH 16: data bus width
SEL_WIDTH 2: number of select lines
TGA_WIDTH 1: address tag width
TGC_WIDTH 1: cycle tag width
TGRD_WIDTH 1: read data tag width
TGWD_WIDTH 1: write data tag width
CNT_WIDTH 2: outstanding counter width; the maximum outstanding count is 2**CNT_WIDTH-1

Ports:
clk_i  in  1  module clock
async_rst_i  in  1  asynchronous reset, active high
itrN_cyc_i, itrN_stb_i, itrN_we_i, itrN_lock_i  in  1 each  initiator N (N=0,1) control
itrN_sel_i  in  SEL_WIDTH  initiator N select lines
itrN_adr_i  in  ADR_WIDTH  initiator N address
itrN_dat_i  in  DAT_WIDTH  initiator N write data
itrN_tga_i, itrN_tgc_i, itrN_tgd_i  in  TGA/TGC/TGWD_WIDTH  initiator N tags
itrN_ack_o, itrN_err_o, itrN_rty_o, itrN_stall_o  out  1 each  response to initiator N
itrN_dat_o  out  DAT_WIDTH  read data to initiator N
itrN_tgd_o  out  TGRD_WIDTH  read data tag to initiator N
tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o  out  1 each  target control
tgt_sel_o, tgt_adr_o, tgt_dat_o  out  SEL/ADR/DAT_WIDTH  target request
tgt_tga_o, tgt_tgc_o, tgt_tgd_o  out  TGA/TGC/TGWD_WIDTH  target tags
tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i  in  1 each  target response
tgt_dat_i  in  DAT_WIDTH  target read data
tgt_tgd_i  in  TGRD_WIDTH  target read data tag
arb_gnt_o  out  2  one-hot grant status, bit N set = itrN owns the bus

Behaviour:
Reset and registered state:
- async_rst_i high sets state IDLE, last-grant pointer to 1 (so itr0 wins the first tie) and counter to 0.
- State, pointer and counter are the only registers; all outputs are combinational from them and the inputs.

FSM states IDLE, GNT0, GNT1; transitions are evaluated each clock edge.
- IDLE with itr0_cyc_i only: go to GNT0.
- IDLE with itr1_cyc_i only: go to GNT1.
- IDLE with both cyc_i high: grant the initiator opposite the pointer.
- Entering GNTx updates the pointer to x.
- GNTx while itrx_cyc_i or itrx_lock_i is high: stay in GNTx.
- GNTx with itrx_cyc_i and itrx_lock_i both low: go to IDLE. IDLE always lasts at least 1 cycle, so tgt_cyc_o drops for at least 1 cycle between owners.
- Grant latency is 1 cycle from cyc_i rising, with a 1-cycle gap on handover.

Output mux in GNTx:
- tgt_cyc_o = itrx_cyc_i.
- tgt_stb_o = itrx_stb_i & ~full.
- we, lock, sel, adr, dat and tags on the target side come from itrx.
- In IDLE: tgt_cyc_o = 0, tgt_stb_o = 0, the other target outputs are 0.

Stall:
- itrx_stall_o = tgt_stall_i | full while granted.
- Any non-granted initiator sees stall_o = 1 and ack/err/rty = 0.
- Read data and read tags are routed from tgt_dat_i/tgt_tgd_i to both initiators unqualified.

Counter (CNT_WIDTH bits):
- acc = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i.
- rsp = tgt_cyc_o & (tgt_ack_i | tgt_err_i | tgt_rty_i) & (cnt != 0).
- acc only: +1. rsp only: -1. acc & rsp in the same cycle: unchanged.
- full = (cnt == 2**CNT_WIDTH-1).
- A target response arriving with cnt == 0, or in IDLE, is dropped: the owner sees ack/err/rty = 0.
- The counter clears to 0 on the transition GNTx to IDLE, abandoning outstanding accesses per Wishbone.

Other rules:
- itrx_ack_o/err_o/rty_o = the respective target response & rsp.
- Lock with cyc low keeps the grant with tgt_cyc_o = 0; the other initiator remains stalled.
- Reset asserted mid-cycle forces IDLE immediately (asynchronously): tgt_cyc_o = 0 and all stalls = 1.

Test Plan:
1. Reset, then itr0_cyc/stb high at cycle 0: arb_gnt_o = 01 at cycle 1; tgt_adr_o = itr0_adr_i; itr1_stall_o = 1 throughout.
2. Both cyc high from IDLE after reset: itr0 granted. itr0 drops cyc: 1 IDLE cycle with tgt_cyc_o = 0, then arb_gnt_o = 10. Repeat: itr0 granted (alternation).
3. CNT_WIDTH = 2, target never acks, itr0 issues 4 stb cycles with tgt_stall_i = 0: cnt reaches 3, the 4th is stalled (itr0_stall_o = 1, tgt_stb_o = 0). One ack: cnt = 2, stall releases.
4. tgt_ack_i pulsed while cnt = 0: itr0_ack_o stays 0, cnt stays 0. acc and ack in the same cycle with cnt = 1: cnt stays 1.
5. itr1 owns the bus, holds lock, drops cyc for 3 cycles while itr0_cyc is high: grant stays 10 and itr0_stall_o = 1. Lock drops: IDLE, then 01.
6. async_rst_i pulsed mid-transfer with cnt = 2: all outputs return to reset values in the same cycle; after release, cnt = 0 and arb_gnt_o = 00.
